// File: rtl/gmux_sel_ctrl.sv
// Select sequencer for a global clock mux: turns enable/disable commands into a
// glitch-safe IS0 sequence with settle and minimum-on windows around ACTIVE.
module gmux_sel_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic CMD_VALID,
    input  logic CMD_EN,
    output logic CMD_READY,
    output logic IS0,
    output logic ACTIVE,
    output logic BUSY,
    output logic DONE
);

    typedef enum logic [1:0] {
        S_OFF        = 2'd0,
        S_ON_SETTLE  = 2'd1,
        S_ON         = 2'd2,
        S_OFF_SETTLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_ON_LOAD = CNT_W'(MIN_ON_CYCLES);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    logic             is0_next, active_next, done_next;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // State register; IS0/ACTIVE/DONE are registered so the mux pin never sees
    // combinational glitches.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= S_OFF;
            cnt    <= '0;
            IS0    <= 1'b0;
            ACTIVE <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            IS0    <= is0_next;
            ACTIVE <= active_next;
            DONE   <= done_next;
        end
    end

    // Next-state and counter.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            S_OFF: begin
                if (accept && CMD_EN) begin
                    state_next = S_ON_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            S_ON_SETTLE: begin
                if (cnt_zero) begin
                    state_next = S_ON;
                    cnt_next   = MIN_ON_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_ON: begin
                if (accept && !CMD_EN) begin
                    state_next = S_OFF_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else if (!cnt_zero) begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_OFF_SETTLE: begin
                if (cnt_zero) begin
                    state_next = S_OFF;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = S_OFF;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: handshake/busy straight from state, registered outputs
    // follow the next state so IS0 moves only on OFF<->SETTLE transitions.
    always_comb begin
        CMD_READY   = (state == S_OFF) || ((state == S_ON) && cnt_zero);
        BUSY        = (state == S_ON_SETTLE) || (state == S_OFF_SETTLE);
        accept      = CMD_VALID && CMD_READY;
        is0_next    = (state_next != S_OFF);
        active_next = (state_next == S_ON);
        done_next   = 1'b0;
        if (BUSY && cnt_zero) begin
            done_next = 1'b1;
        end else if (accept && (state == S_OFF) && !CMD_EN) begin
            done_next = 1'b1;
        end else if (accept && (state == S_ON) && CMD_EN) begin
            done_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Directed bench for gmux_sel_ctrl: a default instance (settle 4, min-on 8) and
// a fast instance (settle 1, min-on 0) for back-to-back commands.
module tb_gmux_sel_ctrl;

    logic CLK;
    logic rstn_a, valid_a, en_a;
    logic ready_a, is0_a, active_a, busy_a, done_a;
    logic rstn_b, valid_b, en_b;
    logic ready_b, is0_b, active_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;
    int done_cnt_b;

    // Observation vector order: {IS0, ACTIVE, DONE, BUSY, CMD_READY}
    logic [4:0] obs_a, obs_b;
    assign obs_a = {is0_a, active_a, done_a, busy_a, ready_a};
    assign obs_b = {is0_b, active_b, done_b, busy_b, ready_b};

    gmux_sel_ctrl #(.SETTLE_CYCLES(4), .MIN_ON_CYCLES(8), .CNT_W(8)) u_dut_a (
        .CLK(CLK), .RSTN(rstn_a), .CMD_VALID(valid_a), .CMD_EN(en_a),
        .CMD_READY(ready_a), .IS0(is0_a), .ACTIVE(active_a), .BUSY(busy_a), .DONE(done_a)
    );

    gmux_sel_ctrl #(.SETTLE_CYCLES(1), .MIN_ON_CYCLES(0), .CNT_W(8)) u_dut_b (
        .CLK(CLK), .RSTN(rstn_b), .CMD_VALID(valid_b), .CMD_EN(en_b),
        .CMD_READY(ready_b), .IS0(is0_b), .ACTIVE(active_b), .BUSY(busy_b), .DONE(done_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and compare instance A's outputs.
    task automatic nc_a(input string tag, input logic [4:0] expected);
        @(negedge CLK);
        check(tag, obs_a, expected);
    endtask

    initial begin
        rstn_a = 1'b0; valid_a = 1'b0; en_a = 1'b0;
        rstn_b = 1'b0; valid_b = 1'b0; en_b = 1'b0;

        // Reset held, then released with no command
        #12;
        check("in_reset", obs_a, 5'b00001);
        @(negedge CLK);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        for (int i = 0; i < 10; i++) nc_a("idle_after_reset", 5'b00001);

        // Enable: accept at edge 0, ACTIVE + DONE after edge 4
        valid_a = 1'b1; en_a = 1'b1;
        nc_a("en_accept", 5'b10010);
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) nc_a("en_settle", 5'b10010);
        nc_a("en_done", 5'b11100);

        // Disable presented at once: held off 8 ON cycles, accepted on the 9th
        valid_a = 1'b1; en_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            nc_a("min_on_hold", 5'b11000);
            en_a = i[0];  // payload may wander while not ready
        end
        en_a = 1'b0;
        nc_a("min_on_ready", 5'b11001);
        nc_a("dis_accept", 5'b10010);
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) nc_a("dis_settle", 5'b10010);
        nc_a("dis_done", 5'b00101);
        nc_a("off_idle", 5'b00001);

        // Redundant enable while ON
        valid_a = 1'b1; en_a = 1'b1;
        nc_a("en2_accept", 5'b10010);
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) nc_a("en2_settle", 5'b10010);
        nc_a("en2_done", 5'b11100);
        for (int i = 0; i < 7; i++) nc_a("en2_hold", 5'b11000);
        nc_a("en2_ready", 5'b11001);
        valid_a = 1'b1; en_a = 1'b1;
        nc_a("redundant_en_done", 5'b11101);
        valid_a = 1'b0;
        nc_a("redundant_en_after", 5'b11001);

        // Full disable, then redundant disable while OFF
        valid_a = 1'b1; en_a = 1'b0;
        nc_a("dis2_accept", 5'b10010);
        valid_a = 1'b0;
        for (int i = 0; i < 3; i++) nc_a("dis2_settle", 5'b10010);
        nc_a("dis2_done", 5'b00101);
        valid_a = 1'b1; en_a = 1'b0;
        nc_a("redundant_dis_done", 5'b00101);
        valid_a = 1'b0;
        nc_a("redundant_dis_after", 5'b00001);

        // Reset two cycles into ON_SETTLE, asserted between clock edges
        valid_a = 1'b1; en_a = 1'b1;
        nc_a("rst_en_accept", 5'b10010);
        valid_a = 1'b0;
        nc_a("rst_en_settle", 5'b10010);
        #2 rstn_a = 1'b0;
        #1 check("async_reset_now", obs_a, 5'b00001);
        nc_a("reset_held", 5'b00001);
        rstn_a = 1'b1;
        nc_a("reset_released_no_done", 5'b00001);
        valid_a = 1'b1; en_a = 1'b1;
        nc_a("first_edge_accept", 5'b10010);
        valid_a = 1'b0;

        // Back-to-back on the fast instance: 4-cycle period per enable+disable
        done_cnt_b = 0;
        valid_b = 1'b1; en_b = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge CLK);
            check("b2b_en_settle", obs_b, 5'b10010);
            check("b2b_inv", {4'b0, active_b & ~is0_b}, 5'b0);
            done_cnt_b += int'(done_b);
            @(negedge CLK);
            check("b2b_on", obs_b, 5'b11101);
            check("b2b_inv", {4'b0, active_b & ~is0_b}, 5'b0);
            done_cnt_b += int'(done_b);
            en_b = 1'b0;
            @(negedge CLK);
            check("b2b_dis_settle", obs_b, 5'b10010);
            check("b2b_inv", {4'b0, active_b & ~is0_b}, 5'b0);
            done_cnt_b += int'(done_b);
            @(negedge CLK);
            check("b2b_off", obs_b, 5'b00101);
            check("b2b_inv", {4'b0, active_b & ~is0_b}, 5'b0);
            done_cnt_b += int'(done_b);
            en_b = 1'b1;
        end
        valid_b = 1'b0;
        check("b2b_done_count", 5'(done_cnt_b), 5'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmux_sel_ctrl.md
Name: gmux_sel_ctrl

Overview:
- Sequencing controller that drives the IS0 select pin of a global clock mux cell from fabric logic.
- Converts enable/disable commands into a glitch-safe select sequence. Enforces a settle window before it reports the gated clock as usable, and a quiesce window before it drops the select.
- Sits in the fabric next to each gated global clock.
- Is the command/driver end of the select interface that the mux cell consumes.

Parameters:
- SETTLE_CYCLES, 4, cycles between a select change and completion (enable: IS0 rise to ACTIVE rise; disable: ACTIVE fall to IS0 fall); must be >= 1
- MIN_ON_CYCLES, 8, minimum cycles in ON before a disable command is accepted; 0 allowed
- CNT_W, 8, counter width; must satisfy 2**CNT_W > max(SETTLE_CYCLES, MIN_ON_CYCLES)

Ports:
- CLK  input  1  controller clock
- RSTN  input  1  reset, asynchronous, active-low
- CMD_VALID  input  1  command present
- CMD_EN  input  1  command payload: 1 = enable clock, 0 = disable clock; sampled with CMD_VALID
- CMD_READY  output  1  command accepted on a cycle with CMD_VALID && CMD_READY
- IS0  output  1  select to the clock mux cell, registered
- ACTIVE  output  1  gated clock confirmed stable and usable, registered
- BUSY  output  1  high in ON_SETTLE and OFF_SETTLE
- DONE  output  1  one-cycle pulse on command completion, registered

Behaviour:
- Clocking and reset
  - Single clock CLK, rising edge.
  - RSTN is asynchronous and active-low.
  - Reset values: state OFF, IS0=0, ACTIVE=0, DONE=0, counter=0.
  - CMD_READY and BUSY decode combinationally from state. Out of reset: CMD_READY=1, BUSY=0.
- States: OFF, ON_SETTLE, ON, OFF_SETTLE (2-bit encoding).
- OFF
  - IS0=0, ACTIVE=0, CMD_READY=1.
  - Accept with CMD_EN=1 at edge k: go to ON_SETTLE, IS0=1 after edge k, counter loads SETTLE_CYCLES-1.
  - Accept with CMD_EN=0 (redundant): stay OFF, DONE=1 after edge k only.
- ON_SETTLE
  - IS0=1, ACTIVE=0, CMD_READY=0.
  - Counter decrements each edge.
  - On the edge where the counter is 0: go to ON, ACTIVE=1, DONE pulses that cycle. ACTIVE rises after edge k+SETTLE_CYCLES.
  - Entering ON loads the counter with MIN_ON_CYCLES.
- ON
  - IS0=1, ACTIVE=1.
  - Counter decrements to 0 and saturates.
  - CMD_READY=1 only when the counter is 0. With MIN_ON_CYCLES=0 it is ready on the first ON cycle.
  - Accept with CMD_EN=0 at edge k: go to OFF_SETTLE, ACTIVE=0 after edge k, IS0 stays 1, counter loads SETTLE_CYCLES-1.
  - Accept with CMD_EN=1 (redundant): stay ON, DONE pulse only.
- OFF_SETTLE
  - IS0=1, ACTIVE=0, CMD_READY=0.
  - On the edge where the counter is 0: go to OFF, IS0=0, DONE pulses. IS0 falls after edge k+SETTLE_CYCLES.
- Invariants
  - ACTIVE=1 implies IS0=1.
  - IS0 changes at most once per command.
  - IS0 never toggles while in a SETTLE state.
  - DONE is never high for two consecutive cycles unless two commands complete back to back, e.g. a redundant command accepted in the cycle after a DONE.
- Handshake
  - CMD_EN is ignored when CMD_VALID=0.
  - A command held with CMD_READY=0 must not be lost. The source holds CMD_VALID/CMD_EN, and the block accepts the command once READY rises.
  - CMD_EN changes while CMD_READY=0 are legal. The value present on the accept edge wins.
- Reset mid-operation
  - Asserting RSTN low in any state forces all outputs to reset values immediately, without waiting for a clock; IS0=0 at once.
  - An in-flight command is discarded and DONE is not generated.
  - After release, the block is in OFF and ready on the first edge.

Test Plan:
- Reset: RSTN=0 then release, no command → IS0=0, ACTIVE=0, DONE=0, BUSY=0, CMD_READY=1 for 10 cycles.
- Enable (SETTLE_CYCLES=4): CMD_VALID=1, CMD_EN=1 accepted at edge 0 → IS0=1 after edge 0. BUSY=1 for 4 cycles. ACTIVE=1 and a single DONE pulse after edge 4.
- Min-on hold-off (MIN_ON_CYCLES=8): disable command presented immediately after ACTIVE rises → CMD_READY=0 for 8 cycles, accepted on the 9th ON cycle. ACTIVE falls after the accept edge. IS0 falls 4 edges later, with DONE in the same cycle.
- Redundant commands: enable while ON, then (after full disable) disable while OFF → DONE pulses once each, one cycle after accept. IS0/ACTIVE unchanged.
- Reset mid-settle: assert RSTN asynchronously 2 cycles into ON_SETTLE → IS0 drops without a clock edge, no DONE. After release the block is in OFF with CMD_READY=1.
- Back-to-back commands: CMD_VALID held high with CMD_EN alternating 1/0 on each accept, SETTLE_CYCLES=1, MIN_ON_CYCLES=0 → period per enable+disable = 4 cycles. ACTIVE=1 implies IS0=1 checked every cycle. DONE count equals accept count.
